spram_wb_arbiter: RTL and testbench

Two-port Wishbone (classic, single-access) arbiter that shares the 8Kx16 single-port on-chip RAM between the J1 data port (port 0) and a second bus master such as a loader or DMA engine (port 1). The block sits between the two masters and the RAM. It picks one master by round-robin and drives the RAM enable, write-enable, address and data. It returns read data and a one-cycle `ack` to the granted master.

---
 rtl/spram_arb_pkg.sv | 17 +
 rtl/rr_pick2.sv | 22 ++
 rtl/spram_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_spram_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_arb_pkg.sv
// spram_arb_pkg: shared types and constants for the SPRAM Wishbone arbiter.
// Holds the FSM state encoding, the port indices and the default widths.
package spram_arb_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;

    localparam logic PORT_J1  = 1'b0;
    localparam logic PORT_EXT = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-request round-robin picker.
// Ports: req[1:0], prio in; gnt_valid, gnt_idx out.
module rr_pick2
    import spram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = PORT_J1;
        unique case (1'b1)
            (req == 2'b11): gnt_idx = prio;
            (req == 2'b10): gnt_idx = PORT_EXT;
            default:        gnt_idx = PORT_J1;
        endcase
    end

endmodule

// File: rtl/spram_wb_arbiter.sv
// spram_wb_arbiter: shares one single-port RAM between two Wishbone
// classic masters (m0 = J1 data port, m1 = loader/DMA), round-robin.
// Ports: clock, reset_n (async, active low); m0_*/m1_* Wishbone slave
// ports (cyc, stb, we, adr, dat_i in; dat_o, ack out); ram_cen,
// ram_wren, ram_address, ram_data out; ram_q in (one cycle after cen).
// Option: define SPRAM_ARB_LOCK_EN to let a master hold the grant for
// back-to-back accesses while it keeps cyc and stb high.
module spram_wb_arbiter
    import spram_arb_pkg::*;
#(
    parameter int addr_width = ADDR_W,
    parameter int data_width = DATA_W
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    input  logic                  m0_we,
    input  logic [addr_width-1:0] m0_adr,
    input  logic [data_width-1:0] m0_dat_i,
    output logic [data_width-1:0] m0_dat_o,
    output logic                  m0_ack,

    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    input  logic                  m1_we,
    input  logic [addr_width-1:0] m1_adr,
    input  logic [data_width-1:0] m1_dat_i,
    output logic [data_width-1:0] m1_dat_o,
    output logic                  m1_ack,

    output logic                  ram_cen,
    output logic                  ram_wren,
    output logic [addr_width-1:0] ram_address,
    output logic [data_width-1:0] ram_data,
    input  logic [data_width-1:0] ram_q
);

    state_t                state;
    logic                  grant;
    logic                  prio;
    logic                  ack0_q;
    logic                  ack1_q;
    logic                  rd_q;
    logic [data_width-1:0] hold0;
    logic [data_width-1:0] hold1;

    logic [1:0]            req;
    logic                  pick_valid;
    logic                  pick_idx;

    logic                  g_cyc;
    logic                  g_we;
    logic [addr_width-1:0] g_adr;
    logic [data_width-1:0] g_dat;

    assign req = {m1_cyc & m1_stb, m0_cyc & m0_stb};

    rr_pick2 u_pick (
        .req       (req),
        .prio      (prio),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    assign g_cyc = grant ? m1_cyc   : m0_cyc;
    assign g_we  = grant ? m1_we    : m0_we;
    assign g_adr = grant ? m1_adr   : m0_adr;
    assign g_dat = grant ? m1_dat_i : m0_dat_i;

`ifdef SPRAM_ARB_LOCK_EN
    logic g_stb;
    assign g_stb = grant ? m1_stb : m0_stb;
`endif

    // The RAM only sees a live address/data while an access is issued;
    // outside ACCESS everything is forced to zero.
    assign ram_cen     = (state == S_ACCESS);
    assign ram_wren    = ram_cen & g_we;
    assign ram_address = ram_cen ? g_adr : '0;
    assign ram_data    = ram_cen ? g_dat : '0;

    assign m0_ack = ack0_q;
    assign m1_ack = ack1_q;

    // ram_q is the RAM's own output register and is valid exactly in the
    // ack cycle, so it is passed through then and held afterwards.
    assign m0_dat_o = (ack0_q && rd_q) ? ram_q : hold0;
    assign m1_dat_o = (ack1_q && rd_q) ? ram_q : hold1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            grant  <= PORT_J1;
            prio   <= PORT_J1;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            rd_q   <= 1'b0;
            hold0  <= '0;
            hold1  <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant <= pick_idx;
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    rd_q <= ~g_we;
                    // A master that dropped cyc gets no ack, but a
                    // write issued this cycle still lands.
                    if (g_cyc) begin
                        if (grant == PORT_EXT) ack1_q <= 1'b1;
                        else                   ack0_q <= 1'b1;
                    end
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (ack0_q && rd_q) hold0 <= ram_q;
                    if (ack1_q && rd_q) hold1 <= ram_q;
`ifdef SPRAM_ARB_LOCK_EN
                    if (g_cyc && g_stb) begin
                        state <= S_ACCESS;
                    end else begin
                        state <= S_IDLE;
                        prio  <= ~grant;
                    end
`else
                    state <= S_IDLE;
                    prio  <= ~grant;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spram_wb_arbiter.sv
// tb_spram_wb_arbiter: scoreboard bench for spram_wb_arbiter with a
// behavioural 8Kx16 RAM; drivers push expectations, a monitor checks acks.
module tb_spram_wb_arbiter;
    import spram_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [12:0] m0_adr = '0;
    logic [15:0] m0_dat_i = '0;
    logic [15:0] m0_dat_o;
    logic        m0_ack;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [12:0] m1_adr = '0;
    logic [15:0] m1_dat_i = '0;
    logic [15:0] m1_dat_o;
    logic        m1_ack;
    logic        ram_cen, ram_wren;
    logic [12:0] ram_address;
    logic [15:0] ram_data;
    logic [15:0] ram_q = '0;

    logic [15:0] mem [0:8191];

    always #5 clock = ~clock;

    spram_wb_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we),
        .m0_adr(m0_adr), .m0_dat_i(m0_dat_i),
        .m0_dat_o(m0_dat_o), .m0_ack(m0_ack),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we),
        .m1_adr(m1_adr), .m1_dat_i(m1_dat_i),
        .m1_dat_o(m1_dat_o), .m1_ack(m1_ack),
        .ram_cen(ram_cen), .ram_wren(ram_wren),
        .ram_address(ram_address), .ram_data(ram_data),
        .ram_q(ram_q)
    );

    // RAM preload: word i holds 0xA000 | i.
    initial begin
        for (int i = 0; i < 8192; i++) mem[i] <= 16'hA000 | 16'(i);
    end

    always @(posedge clock) begin
        if (ram_cen) begin
            if (ram_wren) mem[ram_address] <= ram_data;
            ram_q <= mem[ram_address];
        end
    end

    typedef struct {
        logic        rd;
        logic [15:0] dat;
        int          lat;
        int          start;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;
    int ack_cnt0 = 0;
    int ack_cnt1 = 0;
    int cen_cnt = 0;

    always @(posedge clock) cyc_n <= cyc_n + 1;

    always @(negedge clock) if (reset_n && ram_cen) cen_cnt++;

    task automatic check_ack(input int p, input logic [15:0] d);
        exp_t e;
        if (p == 0) ack_cnt0++; else ack_cnt1++;
        vectors++;
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            miscompares++;
            $display("FAIL unexpected_ack port%0d: got ack=1, want ack=0", p);
            return;
        end
        if (p == 0) e = q0.pop_front(); else e = q1.pop_front();
        if (cyc_n - e.start != e.lat) begin
            miscompares++;
            $display("FAIL ack_latency port%0d: got %0d, want %0d",
                     p, cyc_n - e.start, e.lat);
        end
        if (e.rd) begin
            vectors++;
            if (d !== e.dat) begin
                miscompares++;
                $display("FAIL read_data port%0d: got %h, want %h", p, d, e.dat);
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (m0_ack) check_ack(0, m0_dat_o);
            if (m1_ack) check_ack(1, m1_dat_o);
        end
    end

    task automatic drive(input int p, input logic c, input logic s,
                         input logic w, input logic [12:0] a,
                         input logic [15:0] d);
        if (p == 0) begin
            m0_cyc = c; m0_stb = s; m0_we = w; m0_adr = a; m0_dat_i = d;
        end else begin
            m1_cyc = c; m1_stb = s; m1_we = w; m1_adr = a; m1_dat_i = d;
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? m0_ack : m1_ack;
    endfunction

    task automatic push_exp(input int p, input logic rd,
                            input logic [15:0] dat, input int lat);
        exp_t e;
        e.rd = rd; e.dat = dat; e.lat = lat; e.start = cyc_n;
        if (p == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Wait for this port's ack at negedges; a missing ack is a miscompare.
    task automatic wait_ack(input int p);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ack_of(p) && n < 40);
        if (!ack_of(p)) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout port%0d: got no ack, want ack", p);
            if (p == 0) void'(q0.pop_back()); else void'(q1.pop_back());
        end
    endtask

    // One single access; lat is cycles from stb to ack (ack cycle = +2 solo).
    task automatic xfer(input int p, input logic w, input logic [12:0] a,
                        input logic [15:0] d, input logic [15:0] exp_d,
                        input int lat);
        @(negedge clock);
        push_exp(p, !w, exp_d, lat);
        drive(p, 1'b1, 1'b1, w, a, d);
        wait_ack(p);
        drive(p, 1'b0, 1'b0, w, a, d);
    endtask

    task automatic burst0(input logic [12:0] a0, input int n);
        logic [12:0] a = a0;
        @(negedge clock);
        for (int i = 0; i < n; i++) begin
            push_exp(0, 1'b1, 16'hA000 | 16'(a), 2);
            drive(0, 1'b1, 1'b1, 1'b0, a, 16'h0);
            wait_ack(0);
            a = a + 13'd1;
        end
        drive(0, 1'b0, 1'b0, 1'b0, a, 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int c0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({m0_ack, m1_ack, m0_dat_o, m1_dat_o, ram_cen, ram_wren,
             ram_address, ram_data} != '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got nonzero, want all zero");
        end
        reset_n = 1'b1;
        c0 = cen_cnt;
        repeat (20) @(negedge clock);
        vectors++;
        if (cen_cnt != c0) begin
            miscompares++;
            $display("FAIL idle_cen: got %0d cen cycles, want 0", cen_cnt - c0);
        end

        a1 = ack_cnt1;
        xfer(0, 1'b1, 13'h0123, 16'hBEEF, 16'h0000, 2);
        xfer(0, 1'b0, 13'h0123, 16'h0000, 16'hBEEF, 2);
        repeat (2) @(negedge clock);
        vectors++;
        if (ack_cnt1 != a1) begin
            miscompares++;
            $display("FAIL m1_quiet: got %0d acks, want 0", ack_cnt1 - a1);
        end

        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        fork
            begin
                xfer(0, 1'b0, 13'h0000, 16'h0, 16'hA000, 2);
                xfer(0, 1'b0, 13'h0001, 16'h0, 16'hA001, 5);
                xfer(0, 1'b0, 13'h0002, 16'h0, 16'hA002, 5);
                xfer(0, 1'b0, 13'h0003, 16'h0, 16'hA003, 5);
            end
            begin
                xfer(1, 1'b0, 13'h1FFF, 16'h0, 16'hBFFF, 5);
                xfer(1, 1'b0, 13'h1FFE, 16'h0, 16'hBFFE, 5);
                xfer(1, 1'b0, 13'h1FFD, 16'h0, 16'hBFFD, 5);
                xfer(1, 1'b0, 13'h1FFC, 16'h0, 16'hBFFC, 5);
            end
        join

        fork
            xfer(0, 1'b1, 13'h0040, 16'h1111, 16'h0, 2);
            xfer(1, 1'b1, 13'h0040, 16'h2222, 16'h0, 5);
        join
        xfer(0, 1'b0, 13'h0040, 16'h0, 16'h2222, 2);

        @(negedge clock);
        a1 = ack_cnt1;
        drive(1, 1'b1, 1'b1, 1'b1, 13'h0005, 16'hA5A5);
        @(negedge clock);
        vectors++;
        if (!(ram_cen && ram_wren && ram_address == 13'h0005
              && ram_data == 16'hA5A5)) begin
            miscompares++;
            $display("FAIL abort_issue: got cen=%b wren=%b adr=%h dat=%h, want 1 1 0005 a5a5",
                     ram_cen, ram_wren, ram_address, ram_data);
        end
        drive(1, 1'b0, 1'b0, 1'b1, 13'h0005, 16'hA5A5);
        repeat (3) @(negedge clock);
        vectors++;
        if (ack_cnt1 != a1) begin
            miscompares++;
            $display("FAIL abort_ack: got %0d acks, want 0", ack_cnt1 - a1);
        end
        fork
            xfer(0, 1'b0, 13'h0005, 16'h0, 16'hA5A5, 2);
            xfer(1, 1'b0, 13'h0040, 16'h0, 16'h2222, 5);
        join

`ifdef SPRAM_ARB_LOCK_EN
        fork
            burst0(13'h0100, 4);
            xfer(1, 1'b0, 13'h0200, 16'h0, 16'hA200, 11);
        join
`endif

        repeat (3) @(negedge clock);
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL pending_acks: got %0d/%0d left, want 0/0",
                     q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
